// File: rtl/bus_mem.sv
// ---------------------------------------------------------------------------
// bus_mem -- single-port 16-bit word memory slave for the CPU bus_cyc/bus_ack
// bus. Each request is latched, held for WAIT_STATES extra cycles, then the
// read or write is performed and a one-cycle bus_ack pulse is returned.
//
// Parameters:
//   ADDR_WIDTH  - width of bus_addr in 16-bit words (default 14)
//   DEPTH       - implemented words, DEPTH <= 2**ADDR_WIDTH (default 4096)
//   WAIT_STATES - extra cycles between acceptance and ack, 0..15 (default 1)
//   INIT_FILE   - optional memory image name (default "")
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   bus_addr   - word address
//   bus_wrdata - write data
//   bus_rddata - registered read data, valid from the ack cycle onwards
//   bus_cyc    - request valid, held by the master until ack
//   bus_write  - 1 = write, 0 = read
//   bus_ack    - registered one-cycle completion pulse
//   bus_err    - out-of-range flag, asserted with bus_ack
//                (port exists only when BUS_MEM_ERR_EN is defined)
//
// Optional feature macro: BUS_MEM_ERR_EN
// ---------------------------------------------------------------------------
module bus_mem #(
    parameter int ADDR_WIDTH  = 14,
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [15:0]           bus_wrdata,
    output logic [15:0]           bus_rddata,
    input  logic                  bus_cyc,
    input  logic                  bus_write,
    output logic                  bus_ack
`ifdef BUS_MEM_ERR_EN
    ,
    output logic                  bus_err
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]          CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [15:0]             wdata_q;
    logic                    we_q;
    logic                    live;

    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [15:0]             acc_wdata;
    logic                    acc_we;
    logic                    do_access;
    logic                    in_range;
    logic [IDX_W-1:0]        idx;

    logic [15:0] mem [DEPTH];

    // Select the request that is performed this edge: the live bus inputs
    // for a zero-wait access out of IDLE, otherwise the latched copy.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_we    = we_q;
        do_access = 1'b0;
        if (state == IDLE) begin
            acc_addr  = bus_addr;
            acc_wdata = bus_wrdata;
            acc_we    = bus_write;
            // live keeps a zero-wait request that is present while reset
            // releases from writing memory before the FSM is running.
            do_access = bus_cyc && live && (WAIT_STATES == 0);
        end else if (state == WAIT) begin
            do_access = bus_cyc && (cnt == 4'd0);
        end
    end

    assign in_range = {1'b0, acc_addr} < DEPTH_W;
    assign idx      = acc_addr[IDX_W-1:0];

    // NOTE: the memory array has no reset; contents survive rst_n by design.
    always_ff @(posedge clk) begin
        if (do_access && acc_we && in_range) begin
            mem[idx] <= acc_wdata;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 16'h0000;
            we_q       <= 1'b0;
            live       <= 1'b0;
            bus_ack    <= 1'b0;
            bus_rddata <= 16'h0000;
`ifdef BUS_MEM_ERR_EN
            bus_err    <= 1'b0;
`endif
        end else begin
            live    <= 1'b1;
            bus_ack <= 1'b0;
`ifdef BUS_MEM_ERR_EN
            bus_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus_cyc) begin
                        addr_q  <= bus_addr;
                        wdata_q <= bus_wrdata;
                        we_q    <= bus_write;
                        if (WAIT_STATES > 0) begin
                            cnt   <= CNT_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!bus_cyc) begin
                        state <= IDLE;                 // abort, nothing performed
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase

            if (do_access) begin
                state   <= ACK;
                bus_ack <= 1'b1;
`ifdef BUS_MEM_ERR_EN
                bus_err <= !in_range;
`endif
                if (!acc_we) begin
                    bus_rddata <= in_range ? mem[idx] : 16'h0000;
                end
            end
        end
    end

endmodule
